// File: rtl/bazz_pkg.sv
// Shared definitions for the buzzer sequencer: state encoding, event priorities
// and the mapping from an event's priority to its beep length.
package bazz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_HIT  = 2'd1;
  localparam logic [1:0] PRI_MISS = 2'd2;
  localparam logic [1:0] PRI_OVER = 2'd3;

  localparam int BEEP_W = 8;

  // Hits get the short chirp; misses and every game-over beep use the long tone.
  function automatic int unsigned beep_dur(input logic [1:0] pri,
                                           input int unsigned hit_cyc,
                                           input int unsigned miss_cyc);
    return (pri == PRI_HIT) ? hit_cyc : miss_cyc;
  endfunction

endpackage

// File: rtl/bazz_timer.sv
// Loadable down-counter shared by beep and gap timing; done marks the cycle
// whose edge takes the count from 1 to 0.
module bazz_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign done = en && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/bazz_sequencer.sv
// Turns one-cycle pong events into timed buzzer patterns on fell, with
// priority preemption, a multi-beep game-over pattern and a mute override.
module bazz_sequencer
  import bazz_pkg::*;
#(
  parameter int          CNT_W      = 24,
  parameter int unsigned HIT_CYC    = 2_500_000,
  parameter int unsigned MISS_CYC   = 15_000_000,
  parameter int unsigned GAP_CYC    = 5_000_000,
  parameter int unsigned OVER_BEEPS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic hit_pulse,
  input  logic miss_pulse,
  input  logic over_pulse,
  input  logic mute,
  output logic fell,
  output logic busy
);

  localparam logic [63:0] CNT_LIMIT = 64'd1 << CNT_W;

  if (HIT_CYC == 0 || MISS_CYC == 0 || GAP_CYC == 0 ||
      OVER_BEEPS < 1 || OVER_BEEPS >= (1 << BEEP_W) ||
      64'(HIT_CYC) >= CNT_LIMIT || 64'(MISS_CYC) >= CNT_LIMIT ||
      64'(GAP_CYC) >= CNT_LIMIT) begin : g_bad_params
    $error("bazz_sequencer: duration or beep-count parameter out of range");
  end

  state_t            state_reg, state_next;
  logic [1:0]        pri_reg, pri_next;
  logic [BEEP_W-1:0] beeps_reg, beeps_next;
  logic              fell_reg, fell_next;
  logic              busy_reg, busy_next;

  logic              load;
  logic [CNT_W-1:0]  load_val;
  logic              en;
  logic              done;
  logic [1:0]        evt_pri;
  logic [1:0]        cur_pri;
  logic              last_beep;

  bazz_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .done     (done)
  );

  assign evt_pri   = over_pulse ? PRI_OVER :
                     miss_pulse ? PRI_MISS :
                     hit_pulse  ? PRI_HIT  : PRI_NONE;
  assign en        = (state_reg != IDLE);
  assign last_beep = (state_reg == BEEP) && done && (beeps_reg <= BEEP_W'(1));
  // A pattern finishing on this edge counts as idle, so a coincident event is taken.
  assign cur_pri   = ((state_reg == IDLE) || last_beep) ? PRI_NONE : pri_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pri_reg   <= PRI_NONE;
      beeps_reg <= '0;
      fell_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pri_reg   <= pri_next;
      beeps_reg <= beeps_next;
      fell_reg  <= fell_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pri_next   = pri_reg;
    beeps_next = beeps_reg;
    load       = 1'b0;
    load_val   = '0;
    if (mute) begin
      state_next = IDLE;
      pri_next   = PRI_NONE;
      beeps_next = '0;
      load       = 1'b1;
    end else if (evt_pri > cur_pri) begin
      state_next = BEEP;
      pri_next   = evt_pri;
      beeps_next = (evt_pri == PRI_OVER) ? BEEP_W'(OVER_BEEPS) : BEEP_W'(1);
      load       = 1'b1;
      load_val   = CNT_W'(beep_dur(evt_pri, HIT_CYC, MISS_CYC));
    end else begin
      case (state_reg)
        BEEP: begin
          if (last_beep) begin
            state_next = IDLE;
            pri_next   = PRI_NONE;
            beeps_next = '0;
          end else if (done) begin
            state_next = GAP;
            beeps_next = beeps_reg - BEEP_W'(1);
            load       = 1'b1;
            load_val   = CNT_W'(GAP_CYC);
          end
        end
        GAP: begin
          if (done) begin
            state_next = BEEP;
            load       = 1'b1;
            load_val   = CNT_W'(MISS_CYC);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fell_next = (state_next == BEEP);
    busy_next = (state_next != IDLE);
  end

  assign fell = fell_reg;
  assign busy = busy_reg;

endmodule

// File: doc/bazz_sequencer.md
Name: bazz_sequencer

Overview:
- Upstream of the buzzer output stage.
- Converts single-cycle game events from the pong game logic (paddle hit, ball miss, game over) into a timed `fell` level.
- The buzzer stage consumes `fell` and sounds while it is high.
- Owns all sound timing, so game logic only emits one-cycle pulses.

Parameters:
- CNT_W, 24, width of the duration counter. It must hold the largest of HIT_CYC, MISS_CYC and GAP_CYC.
- HIT_CYC, 2_500_000, fell-high duration in clk cycles for a paddle hit (50 ms at 50 MHz).
- MISS_CYC, 15_000_000, fell-high duration for a miss, and for each game-over beep (300 ms).
- GAP_CYC, 5_000_000, fell-low gap between game-over beeps (100 ms).
- OVER_BEEPS, 3, number of beeps in the game-over pattern; minimum value is 1.

Ports:
- clk, input, 1, system clock (same clock fed to the buzzer stage).
- rst, input, 1, synchronous active-high reset.
- hit_pulse, input, 1, one-cycle pulse: ball struck a paddle.
- miss_pulse, input, 1, one-cycle pulse: ball passed a paddle.
- over_pulse, input, 1, one-cycle pulse: game over.
- mute, input, 1, level; when high, suppresses all sound.
- fell, output, 1, registered level to the buzzer stage; high = sound.
- busy, output, 1, registered; high while any pattern is in progress.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - fell=0, busy=0, state=IDLE.
  - Duration counter = 0, beep counter = 0.
  - Reset mid-pattern aborts it immediately.
- States and priority:
  - States are IDLE, BEEP, GAP. Each event class has a priority: OVER=3, MISS=2, HIT=1, none=0.
  - Simultaneous pulses on one edge resolve to the highest-priority class; the others are dropped.
- Event acceptance (mute=0):
  - An event accepted at edge N gives fell=1 and busy=1 from edge N (visible after N); latency is 1 cycle.
  - The counter loads the class duration. The class priority is stored as the current priority.
  - The beep counter loads OVER_BEEPS for OVER and 1 otherwise.
- BEEP state:
  - The counter decrements each cycle, so fell stays high exactly DUR cycles.
  - When the counter expires with beeps remaining above 1: go to GAP, fell=0, counter=GAP_CYC, beep counter decrements.
  - When it expires on the last beep: go to IDLE, fell=0, busy=0. There is no trailing gap.
- GAP state:
  - Lasts exactly GAP_CYC cycles with fell=0 and busy=1, then returns to BEEP with counter=MISS_CYC.
- Preemption:
  - An event arriving while busy with priority strictly greater than the current priority restarts immediately as a fresh acceptance. fell goes or stays 1 on the next edge.
  - An event of equal or lower priority is ignored; the pattern in progress is not extended.
- Back-to-back events:
  - A pulse on the same edge that the pattern completes is treated as arriving in IDLE, so it is accepted.
- mute:
  - mute=1 in IDLE: events are ignored.
  - mute rising mid-pattern: abort to IDLE on the next edge (fell=0, busy=0).
  - mute has priority over any simultaneous event.
- Counter rules:
  - The counter is unsigned CNT_W bits and never wraps.
  - A duration of 0 is illegal; out-of-range parameters are caught by a parameter check at elaboration.

Decomposition:
- Shared package bazz_pkg:
  - State encoding: IDLE=2'd0, BEEP=2'd1, GAP=2'd2.
  - Priority constants: PRI_NONE=0, PRI_HIT=1, PRI_MISS=2, PRI_OVER=3.
  - A function mapping priority to beep duration.
- One sub-module, bazz_timer:
  - Loadable down-counter with load, load_val, en, and a one-cycle `done` output when it hits 0.
  - Instantiated once for both beep and gap timing.

Test Plan (HIT_CYC=4, MISS_CYC=10, GAP_CYC=3, OVER_BEEPS=3):
- hit_pulse at cycle 5 -> fell=1 for cycles 6..9, fell=0 at cycle 10; busy mirrors fell.
- over_pulse at cycle 0:
  - fell high on 1-10, 14-23 and 27-36.
  - fell low on 11-13 and 24-26.
  - busy falls at 37.
- hit_pulse and miss_pulse on the same edge -> MISS wins: 10-cycle beep, no hit beep afterwards.
- Preemption and ignore:
  - miss_pulse, then hit_pulse 3 cycles later -> hit ignored, single 10-cycle beep.
  - miss_pulse, then over_pulse 3 cycles later -> full game-over pattern starts the cycle after over_pulse.
- Mute:
  - mute raised during the second game-over beep -> fell=0 and busy=0 on the next edge.
  - hit_pulse with mute=1 -> no fell activity.
- Reset:
  - rst pulsed one cycle mid-GAP -> fell=0 and busy=0 after that edge; the pattern does not resume after rst drops.
  - A new hit_pulse after reset gives a clean 4-cycle beep.
